div_ctrl: RTL and testbench

Sequencer for the multi-cycle DIV/DIVU datapath behind the ALU. It accepts a divide request via the ALU's start/signed handshake, runs a 32-iteration restoring division, and reports completion with `ready`. It presents the result as the 64-bit HI/LO pair: remainder in HI, quotient in LO. The ALU holds the pipeline stalled until `ready` is asserted, and a pipeline flush can abort the operation.

---
 rtl/div_ctrl_pkg.sv | 20 ++
 rtl/div_step.sv | 17 +
 rtl/div_ctrl.sv | 132 +++++++++++++
 tb/tb_div_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the DIV/DIVU sequencer: state encodings, iteration
// count, divide-by-zero result and an operand magnitude helper.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int          DIV_ITER        = 32;
    localparam logic [63:0] DIV_ZERO_RESULT = 64'h0;

    // Two's complement magnitude when the operand is signed and negative.
    // 0x80000000 maps to itself, which reads correctly as unsigned 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract the divisor from the
// shifted partial remainder and keep the difference when it does not borrow.
module div_step (
    input  logic [32:0] part_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] part_o,
    output logic        qbit_o
);

    logic [32:0] diff;

    // The partial remainder is always below the divisor, so a borrow shows up in bit 32.
    assign diff   = part_i - {1'b0, divisor_i};
    assign qbit_o = ~diff[32];
    assign part_o = qbit_o ? diff[31:0] : part_i[31:0];

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: 32 restoring steps on operand magnitudes,
// sign fixup on completion, result presented as {remainder, quotient}.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_div,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic        ready,
    output logic [63:0] result
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] part_q, part_d;
    logic [31:0] quot_q, quot_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        ready_q, ready_d;
    logic [63:0] result_q, result_d;

    logic [31:0] step_part;
    logic        step_qbit;
    logic        last_step;
    logic [31:0] q_fin;

    div_step u_step (
        .part_i    ({part_q, dvd_q[31]}),
        .divisor_i (dvs_q),
        .part_o    (step_part),
        .qbit_o    (step_qbit)
    );

    assign last_step = (cnt_q == 5'(DIV_ITER - 1));
    assign q_fin     = {quot_q[30:0], step_qbit};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= DIV_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start_div) state_d = (opdata2 == 32'h0) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (last_step) state_d = DIV_DONE;
            DIV_DONE: if (!start_div) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (annul) state_d = DIV_IDLE;
    end

    always_comb begin
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        part_d   = part_q;
        quot_d   = quot_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        ready_d  = ready_q;
        result_d = result_q;
        case (state_q)
            DIV_IDLE: begin
                if (start_div && opdata2 == 32'h0) begin
                    result_d = DIV_ZERO_RESULT;
                    ready_d  = 1'b1;
                end else if (start_div) begin
                    dvd_d  = mag32(opdata1, signed_div);
                    dvs_d  = mag32(opdata2, signed_div);
                    qneg_d = signed_div & (opdata1[31] ^ opdata2[31]);
                    rneg_d = signed_div & opdata1[31];
                    cnt_d  = '0;
                    part_d = '0;
                    quot_d = '0;
                end
            end
            DIV_BUSY: begin
                part_d = step_part;
                quot_d = q_fin;
                dvd_d  = {dvd_q[30:0], 1'b0};
                cnt_d  = cnt_q + 5'd1;
                if (last_step) begin
                    // Remainder follows the dividend sign; quotient negates on sign mismatch.
                    result_d = {rneg_q ? (~step_part + 32'd1) : step_part,
                                qneg_q ? (~q_fin + 32'd1) : q_fin};
                    ready_d  = 1'b1;
                end
            end
            DIV_DONE: if (!start_div) ready_d = 1'b0;
            default:  ready_d = 1'b0;
        endcase
        if (annul) begin
            ready_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            part_q   <= '0;
            quot_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= DIV_ZERO_RESULT;
        end else begin
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            part_q   <= part_d;
            quot_q   <= quot_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    assign ready  = ready_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: stimulus pushes expected {result, latency}
// into a scoreboard; a monitor compares on every rising edge of ready.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_div = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        annul = 1'b0;
    logic        ready;
    logic [63:0] result;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic rdy_prev = 1'b0;

    logic [63:0] exp_res_q[$];
    int          exp_lat_q[$];

    div_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_div  (start_div),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising edge of ready must match the oldest expectation.
    always @(negedge clk) begin
        if (ready && !rdy_prev) begin
            if (exp_res_q.size() == 0) begin
                check("unexpected_ready", 64'(ready), 64'(0));
            end else begin
                check("result", result, exp_res_q.pop_front());
                check("latency", 64'(cyc - start_cyc), 64'(exp_lat_q.pop_front()));
            end
        end
        rdy_prev = ready;
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp, input int lat);
        int n;
        exp_res_q.push_back(exp);
        exp_lat_q.push_back(lat);
        @(negedge clk);
        start_div  = 1'b1;
        signed_div = s;
        opdata1    = a;
        opdata2    = b;
        start_cyc  = cyc;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
            // Operand changes after acceptance must be ignored.
            if (n == 5) begin
                opdata1    = 32'h1234_5678;
                opdata2    = 32'h0000_0003;
                signed_div = ~s;
            end
        end
        if (!ready) begin
            check("ready_timeout", 64'(ready), 64'(1));
            void'(exp_res_q.pop_back());
            void'(exp_lat_q.pop_back());
        end
        @(negedge clk);
        check("ready_hold", 64'(ready), 64'(1));
        check("result_hold", result, exp);
        start_div = 1'b0;
        @(negedge clk);
        check("ready_drop", 64'(ready), 64'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready), 64'(0));
        check("rst_result", result, 64'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        run_div(32'd7, 32'd2, 1'b0, {32'd1, 32'd3}, 33);
        run_div(32'd5, 32'd0, 1'b0, 64'h0, 1);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF}, 33);

        // Flush mid-divide: no ready, result keeps the previous value.
        @(negedge clk);
        start_div = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd3;
        repeat (11) @(negedge clk);
        annul = 1'b1; start_div = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        check("annul_ready", 64'(ready), 64'(0));
        repeat (40) @(negedge clk);
        check("annul_result", result, {32'h0, 32'hFFFF_FFFF});
        run_div(32'd9, 32'd4, 1'b0, {32'd1, 32'd2}, 33);

        // Asynchronous reset mid-divide.
        @(negedge clk);
        start_div = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
        repeat (6) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("areset_ready", 64'(ready), 64'(0));
        check("areset_result", result, 64'h0);
        start_div = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_div(32'd10, 32'd3, 1'b0, {32'd1, 32'd3}, 33);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_res_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
